// File: rtl/neuron_config_loader.sv
// Config-bus transmitter: decodes two-word packet headers and broadcasts weight/bias payload words to the neurons.
// Optional LOADER_STATS_EN adds pkt_count/word_count statistics outputs.
module neuron_config_loader #(
    parameter int dataWidth  = 16,
    parameter int numLayers  = 4,
    parameter int maxNeurons = 256,
    parameter int maxWeights = 784
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    output logic        weightValid,
    output logic        biasValid,
    output logic [31:0] weightValue,
    output logic [31:0] biasValue,
    output logic [31:0] config_layer_num,
    output logic [31:0] config_neuron_num,
    output logic        pkt_done,
    output logic        err,
    output logic [1:0]  err_code
`ifdef LOADER_STATS_EN
    ,
    output logic [15:0] pkt_count,
    output logic [31:0] word_count
`endif
);

    if (dataWidth < 1 || dataWidth > 32) begin : g_width_check
        $error("neuron_config_loader: dataWidth must be 1..32");
    end

    typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, DRAIN} state_t;

    state_t      state, state_nx;
    logic        type_sh;
    logic [7:0]  layer_sh;
    logic [15:0] neuron_sh;
    logic [15:0] remaining;
    logic [15:0] hdr_count;
    logic        accept;
    logic        hdr_ok;
    logic        emit;
    logic        done_nx;
    logic        err_ev;
    logic [1:0]  code_ev;
    logic        load_cfg;

    assign s_tready  = 1'b1;
    assign accept    = s_tvalid & s_tready;
    assign hdr_count = s_tdata[15:0];

    // Header legality is judged on the HDR1 beat against the shadowed word-0 fields
    assign hdr_ok = (int'({24'd0, layer_sh}) < numLayers) &&
                    (int'({16'd0, neuron_sh}) < maxNeurons) &&
                    (type_sh ? (hdr_count == 16'd1)
                             : (hdr_count != 16'd0 && int'({16'd0, hdr_count}) <= maxWeights)) &&
                    !s_tlast;

    always_ff @(posedge clk) begin
        if (!reset) state <= HDR0;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        done_nx  = 1'b0;
        err_ev   = 1'b0;
        code_ev  = 2'd0;
        load_cfg = 1'b0;
        if (accept) begin
            unique case (state)
                HDR0: begin
                    if (s_tlast) begin
                        err_ev  = 1'b1;
                        code_ev = 2'd1;
                    end else begin
                        state_nx = HDR1;
                    end
                end
                HDR1: begin
                    if (hdr_ok) begin
                        load_cfg = 1'b1;
                        state_nx = PAYLOAD;
                    end else begin
                        err_ev   = 1'b1;
                        code_ev  = 2'd1;
                        state_nx = s_tlast ? HDR0 : DRAIN;
                    end
                end
                PAYLOAD: begin
                    emit = 1'b1;
                    if (remaining == 16'd1) begin
                        if (s_tlast) begin
                            done_nx  = 1'b1;
                            state_nx = HDR0;
                        end else begin
                            err_ev   = 1'b1;
                            code_ev  = 2'd3;
                            state_nx = DRAIN;
                        end
                    end else if (s_tlast) begin
                        err_ev   = 1'b1;
                        code_ev  = 2'd2;
                        state_nx = HDR0;
                    end
                end
                DRAIN: begin
                    if (s_tlast) state_nx = HDR0;
                end
                default: state_nx = HDR0;
            endcase
        end
    end

    // Output stage: everything below becomes visible one cycle after the accepted beat
    always_ff @(posedge clk) begin
        if (!reset) begin
            weightValid       <= 1'b0;
            biasValid         <= 1'b0;
            weightValue       <= '0;
            biasValue         <= '0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
            pkt_done          <= 1'b0;
            err               <= 1'b0;
            err_code          <= 2'd0;
            type_sh           <= 1'b0;
            layer_sh          <= '0;
            neuron_sh         <= '0;
            remaining         <= '0;
        end else begin
            weightValid <= emit & ~type_sh;
            biasValid   <= emit & type_sh;
            pkt_done    <= done_nx;
            if (emit && !type_sh) weightValue <= s_tdata;
            if (emit && type_sh)  biasValue   <= s_tdata;
            if (err_ev) begin
                err      <= 1'b1;
                err_code <= code_ev;
            end
            if (state == HDR0 && accept) begin
                type_sh   <= s_tdata[31];
                layer_sh  <= s_tdata[23:16];
                neuron_sh <= s_tdata[15:0];
            end
            if (load_cfg) begin
                config_layer_num  <= {24'd0, layer_sh};
                config_neuron_num <= {16'd0, neuron_sh};
                remaining         <= hdr_count;
            end else if (emit) begin
                remaining <= remaining - 16'd1;
            end
        end
    end

`ifdef LOADER_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            pkt_count  <= '0;
            word_count <= '0;
        end else begin
            if (done_nx) pkt_count  <= pkt_count + 16'd1;
            if (emit)    word_count <= word_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_neuron_config_loader.sv
// Directed, table-driven bench for neuron_config_loader; stats checks compile in with LOADER_STATS_EN.
module tb_neuron_config_loader;

    logic        clk;
    logic        reset;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        weightValid;
    logic        biasValid;
    logic [31:0] weightValue;
    logic [31:0] biasValue;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;
    logic        pkt_done;
    logic        err;
    logic [1:0]  err_code;
`ifdef LOADER_STATS_EN
    logic [15:0] pkt_count;
    logic [31:0] word_count;
`endif

    int checks   = 0;
    int failures = 0;

    neuron_config_loader dut (
        .clk               (clk),
        .reset             (reset),
        .s_tdata           (s_tdata),
        .s_tvalid          (s_tvalid),
        .s_tready          (s_tready),
        .s_tlast           (s_tlast),
        .weightValid       (weightValid),
        .biasValid         (biasValid),
        .weightValue       (weightValue),
        .biasValue         (biasValue),
        .config_layer_num  (config_layer_num),
        .config_neuron_num (config_neuron_num),
        .pkt_done          (pkt_done),
        .err               (err),
        .err_code          (err_code)
`ifdef LOADER_STATS_EN
        ,
        .pkt_count         (pkt_count),
        .word_count        (word_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        v;
        logic        l;
        logic        wv;
        logic        bv;
        logic        done;
        logic        e;
        logic [1:0]  code;
        logic [31:0] wval;
        logic [31:0] bval;
        logic [31:0] lay;
        logic [31:0] neu;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] d, input logic v, input logic l,
                       input logic wv, input logic bv, input logic done,
                       input logic e, input logic [1:0] code,
                       input logic [31:0] wval, input logic [31:0] bval,
                       input logic [31:0] lay, input logic [31:0] neu);
        vec_t r;
        r.d = d; r.v = v; r.l = l; r.wv = wv; r.bv = bv; r.done = done;
        r.e = e; r.code = code; r.wval = wval; r.bval = bval; r.lay = lay; r.neu = neu;
        vecs.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [31:0] d, input logic v, input logic l);
        s_tdata  = d;
        s_tvalid = v;
        s_tlast  = l;
        @(posedge clk);
        #1;
    endtask

    int pulses;
    int done_at;

    initial begin
        reset    = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tready", {31'd0, s_tready}, 32'd1);
        chk("rst_wv", {31'd0, weightValid}, 32'd0);
        chk("rst_bv", {31'd0, biasValid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_code", {30'd0, err_code}, 32'd0);
        chk("rst_layer", config_layer_num, 32'd0);
        chk("rst_done", {31'd0, pkt_done}, 32'd0);
        reset = 1'b1;

        //   data          v  l  wv bv dn e  code wval       bval       lay neu
        // weight packet layer 1 neuron 3, count 4, with a one-beat gap
        add(32'h0001_0003, 1, 0, 0, 0, 0, 0, 0, 32'h0,     32'h0,     0,  0);
        add(32'd4,         1, 0, 0, 0, 0, 0, 0, 32'h0,     32'h0,     1,  3);
        add(32'h11,        1, 0, 1, 0, 0, 0, 0, 32'h11,    32'h0,     1,  3);
        add(32'h22,        1, 0, 1, 0, 0, 0, 0, 32'h22,    32'h0,     1,  3);
        add(32'hDEAD,      0, 0, 0, 0, 0, 0, 0, 32'h22,    32'h0,     1,  3);
        add(32'h33,        1, 0, 1, 0, 0, 0, 0, 32'h33,    32'h0,     1,  3);
        add(32'h44,        1, 1, 1, 0, 1, 0, 0, 32'h44,    32'h0,     1,  3);
        // bias packet layer 0 neuron 7
        add(32'h8000_0007, 1, 0, 0, 0, 0, 0, 0, 32'h44,    32'h0,     1,  3);
        add(32'd1,         1, 0, 0, 0, 0, 0, 0, 32'h44,    32'h0,     0,  7);
        add(32'hABCD,      1, 1, 0, 1, 1, 0, 0, 32'h44,    32'hABCD,  0,  7);
        // bad header: layer 4, then two drained beats
        add(32'h0004_0002, 1, 0, 0, 0, 0, 0, 0, 32'h44,    32'hABCD,  0,  7);
        add(32'd2,         1, 0, 0, 0, 0, 1, 1, 32'h44,    32'hABCD,  0,  7);
        add(32'h55,        1, 0, 0, 0, 0, 1, 1, 32'h44,    32'hABCD,  0,  7);
        add(32'h66,        1, 1, 0, 0, 0, 1, 1, 32'h44,    32'hABCD,  0,  7);
        // legal packet after the bad one
        add(32'h0002_0005, 1, 0, 0, 0, 0, 1, 1, 32'h44,    32'hABCD,  0,  7);
        add(32'd1,         1, 0, 0, 0, 0, 1, 1, 32'h44,    32'hABCD,  2,  5);
        add(32'h77,        1, 1, 1, 0, 1, 1, 1, 32'h77,    32'hABCD,  2,  5);
        // early tlast: count 5, tlast on the 3rd word
        add(32'h0003_00FF, 1, 0, 0, 0, 0, 1, 1, 32'h77,    32'hABCD,  2,  5);
        add(32'd5,         1, 0, 0, 0, 0, 1, 1, 32'h77,    32'hABCD,  3,  255);
        add(32'h1,         1, 0, 1, 0, 0, 1, 1, 32'h1,     32'hABCD,  3,  255);
        add(32'h2,         1, 0, 1, 0, 0, 1, 1, 32'h2,     32'hABCD,  3,  255);
        add(32'h3,         1, 1, 1, 0, 0, 1, 2, 32'h3,     32'hABCD,  3,  255);
        // missing tlast: count 2, four beats
        add(32'h0000_0001, 1, 0, 0, 0, 0, 1, 2, 32'h3,     32'hABCD,  3,  255);
        add(32'd2,         1, 0, 0, 0, 0, 1, 2, 32'h3,     32'hABCD,  0,  1);
        add(32'hA,         1, 0, 1, 0, 0, 1, 2, 32'hA,     32'hABCD,  0,  1);
        add(32'hB,         1, 0, 1, 0, 0, 1, 3, 32'hB,     32'hABCD,  0,  1);
        add(32'hC,         1, 0, 0, 0, 0, 1, 3, 32'hB,     32'hABCD,  0,  1);
        add(32'hD,         1, 1, 0, 0, 0, 1, 3, 32'hB,     32'hABCD,  0,  1);
        // tlast on header word 0
        add(32'h0001_0001, 1, 1, 0, 0, 0, 1, 1, 32'hB,     32'hABCD,  0,  1);
        // neuron 256 out of range
        add(32'h0000_0100, 1, 0, 0, 0, 0, 1, 1, 32'hB,     32'hABCD,  0,  1);
        add(32'd1,         1, 1, 0, 0, 0, 1, 1, 32'hB,     32'hABCD,  0,  1);
        // bias with count 2
        add(32'h8000_0000, 1, 0, 0, 0, 0, 1, 1, 32'hB,     32'hABCD,  0,  1);
        add(32'd2,         1, 1, 0, 0, 0, 1, 1, 32'hB,     32'hABCD,  0,  1);
        // weights with count 0 and count 785
        add(32'h0000_0000, 1, 0, 0, 0, 0, 1, 1, 32'hB,     32'hABCD,  0,  1);
        add(32'd0,         1, 1, 0, 0, 0, 1, 1, 32'hB,     32'hABCD,  0,  1);
        add(32'h0000_0000, 1, 0, 0, 0, 0, 1, 1, 32'hB,     32'hABCD,  0,  1);
        add(32'd785,       1, 1, 0, 0, 0, 1, 1, 32'hB,     32'hABCD,  0,  1);
        // clean bias packet confirms HDR0
        add(32'h8001_0002, 1, 0, 0, 0, 0, 1, 1, 32'hB,     32'hABCD,  0,  1);
        add(32'd1,         1, 0, 0, 0, 0, 1, 1, 32'hB,     32'hABCD,  1,  2);
        add(32'hBEEF,      1, 1, 0, 1, 1, 1, 1, 32'hB,     32'hBEEF,  1,  2);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].d, vecs[i].v, vecs[i].l);
            chk($sformatf("row%0d_wv", i),    {31'd0, weightValid}, {31'd0, vecs[i].wv});
            chk($sformatf("row%0d_bv", i),    {31'd0, biasValid},   {31'd0, vecs[i].bv});
            chk($sformatf("row%0d_done", i),  {31'd0, pkt_done},    {31'd0, vecs[i].done});
            chk($sformatf("row%0d_err", i),   {31'd0, err},         {31'd0, vecs[i].e});
            chk($sformatf("row%0d_code", i),  {30'd0, err_code},    {30'd0, vecs[i].code});
            chk($sformatf("row%0d_wval", i),  weightValue,          vecs[i].wval);
            chk($sformatf("row%0d_bval", i),  biasValue,            vecs[i].bval);
            chk($sformatf("row%0d_layer", i), config_layer_num,     vecs[i].lay);
            chk($sformatf("row%0d_neuron", i), config_neuron_num,   vecs[i].neu);
            chk($sformatf("row%0d_tready", i), {31'd0, s_tready},   32'd1);
        end
`ifdef LOADER_STATS_EN
        chk("stats_pkt_after_table", {16'd0, pkt_count}, 32'd4);
        chk("stats_word_after_table", word_count, 32'd12);
`endif

        // maximum-length weight packet: 784 words, layer 3 neuron 255
        pulses  = 0;
        done_at = 0;
        step(32'h0003_00FF, 1, 0);
        step(32'd784, 1, 0);
        chk("max_layer", config_layer_num, 32'd3);
        chk("max_neuron", config_neuron_num, 32'd255);
        for (int i = 1; i <= 784; i++) begin
            step(i, 1'b1, i == 784);
            if (weightValid) pulses++;
            if (pkt_done) done_at = i;
        end
        chk("max_pulses", pulses, 32'd784);
        chk("max_done_at", done_at, 32'd784);
        chk("max_last_value", weightValue, 32'd784);
        chk("max_code_kept", {30'd0, err_code}, 32'd1);

        // reset in the middle of a 4-word packet, after the 2nd weight
        step(32'h0001_0003, 1, 0);
        step(32'd4, 1, 0);
        step(32'h11, 1, 0);
        step(32'h22, 1, 0);
        chk("pre_rst_wv", {31'd0, weightValid}, 32'd1);
`ifdef LOADER_STATS_EN
        chk("pre_rst_pkt", {16'd0, pkt_count}, 32'd5);
        chk("pre_rst_words", word_count, 32'd798);
`endif
        reset    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("mid_rst_wv", {31'd0, weightValid}, 32'd0);
        chk("mid_rst_bv", {31'd0, biasValid}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_code", {30'd0, err_code}, 32'd0);
        chk("mid_rst_tready", {31'd0, s_tready}, 32'd1);
        chk("mid_rst_wval", weightValue, 32'd0);
        chk("mid_rst_layer", config_layer_num, 32'd0);
`ifdef LOADER_STATS_EN
        chk("mid_rst_pkt", {16'd0, pkt_count}, 32'd0);
        chk("mid_rst_words", word_count, 32'd0);
`endif
        // the next word must be decoded as a header word 0
        step(32'h8002_0004, 1, 0);
        step(32'd1, 1, 0);
        chk("post_rst_layer", config_layer_num, 32'd2);
        chk("post_rst_neuron", config_neuron_num, 32'd4);
        step(32'h1234, 1, 1);
        chk("post_rst_bv", {31'd0, biasValid}, 32'd1);
        chk("post_rst_wv", {31'd0, weightValid}, 32'd0);
        chk("post_rst_bval", biasValue, 32'h1234);
        chk("post_rst_done", {31'd0, pkt_done}, 32'd1);
        chk("post_rst_err", {31'd0, err}, 32'd0);
        step(32'h0, 0, 0);
        chk("post_rst_bv_drop", {31'd0, biasValid}, 32'd0);
        chk("post_rst_done_drop", {31'd0, pkt_done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_config_loader.md
Name: neuron_config_loader

Overview:
- Transmit side of the neuron weight/bias configuration bus. Accepts a 32-bit packetised stream from the host/DMA side (valid/ready/last).
- Decodes a two-word header per packet and broadcasts payload words on the shared config bus (weightValid/biasValid, weightValue/biasValue, config_layer_num/config_neuron_num) consumed by every neuron.
- Enforces exact payload length, because each neuron's weight write address advances once per accepted weight and never rewinds except on reset.

Parameters:
- dataWidth, 16, neuron data width; payload words are forwarded unmodified as 32 bits, and neurons use bits [dataWidth-1:0].
- numLayers, 4, valid layer indices are 0..numLayers-1.
- maxNeurons, 256, valid neuron indices are 0..maxNeurons-1.
- maxWeights, 784, largest legal weight count in one packet.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low; all state is cleared on a rising clk edge while reset==0.
- s_tdata  in  32  stream data.
- s_tvalid  in  1  stream beat valid.
- s_tready  out  1  loader can accept a beat.
- s_tlast  in  1  last beat of packet.
- weightValid  out  1  one-cycle pulse per weight word.
- biasValid  out  1  one-cycle pulse for the bias word.
- weightValue  out  32  weight payload.
- biasValue  out  32  bias payload.
- config_layer_num  out  32  target layer, zero-extended.
- config_neuron_num  out  32  target neuron, zero-extended.
- pkt_done  out  1  one-cycle pulse when a packet completes cleanly.
- err  out  1  sticky error flag.
- err_code  out  2  last error: 1 = bad header, 2 = early tlast, 3 = missing tlast.

Behaviour:
- Reset values: all outputs 0, except s_tready=1. FSM starts in HDR0.
- A beat is accepted when s_tvalid & s_tready.
- s_tready is 1 in every state; the block never back-pressures.
- Header word 0:
  - bit31 = type (0 = weights, 1 = bias).
  - [23:16] = layer.
  - [15:0] = neuron.
- Header word 1: [15:0] = count.
- FSM states:
  - HDR0: on accept, latch type/layer/neuron into shadow registers.
    - If s_tlast=1: err_code=1, stay in HDR0.
    - Otherwise go to HDR1.
  - HDR1: on accept, validate the header. It is legal when all of the following hold:
    - layer<numLayers and neuron<maxNeurons.
    - Weights: 1<=count<=maxWeights. Bias: count==1.
    - s_tlast=0.
  - HDR1, legal header: copy shadow layer/neuron to config_layer_num/config_neuron_num (registered, visible the next cycle), load remaining=count, go to PAYLOAD.
  - HDR1, illegal header: err_code=1. Go to HDR0 if s_tlast=1, else to DRAIN. config_* is not changed.
  - PAYLOAD: each accepted beat drives weightValue/biasValue<=s_tdata and pulses weightValid or biasValid (per type) exactly one cycle later. remaining is decremented.
    - remaining==1 and s_tlast=1: pulse pkt_done with the final valid, go to HDR0.
    - remaining==1 and s_tlast=0: err_code=3, go to DRAIN. The final word is still emitted.
    - remaining>1 and s_tlast=1: err_code=2, go to HDR0. Words already sent are not retracted.
  - DRAIN: accept and discard beats with no valids; on an accepted beat with s_tlast=1, go to HDR0.
- err is set on any error and cleared only by reset. Each error event overwrites err_code.
- Holding behaviour:
  - config_layer_num/config_neuron_num hold until the next legal header.
  - weightValue/biasValue hold their last value; only the valids pulse.
- Timing guarantee: config_* change at least one cycle before the first payload valid of the packet. The earliest first valid is two cycles after the HDR1 accept.
- Back-to-back beats produce back-to-back valid pulses; s_tvalid gaps produce gaps with no pulses.
- weightValid and biasValid are never both high.
- Reset asserted mid-packet:
  - Returns to HDR0 next cycle; all pulses drop.
  - Remaining payload is interpreted as headers, which the host must avoid; neurons are reset on the same reset.

Optional Feature:
- Macro LOADER_STATS_EN.
- When defined, adds these outputs:
  - pkt_count out 16: clean packets completed, increments with pkt_done, wraps at 65535->0.
  - word_count out 32: total payload valids emitted, wraps.
- Both counters reset to 0.
- When undefined, the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Weight packet: header {0,layer 1,neuron 3}, count 4, data 0x11..0x44, tlast on the 4th data beat, s_tvalid continuous -> config_layer_num=1 and config_neuron_num=3 before the first pulse; 4 consecutive weightValid pulses carrying 0x11,0x22,0x33,0x44; pkt_done coincident with the 4th; err=0.
- Bias packet: header {1,layer 0,neuron 7}, count 1, data 0x0000ABCD with tlast -> a single biasValid with biasValue=0x0000ABCD, no weightValid, pkt_done=1.
- Bad header, layer=numLayers (4), count 2, then 2 data beats with tlast -> no valids, err=1, err_code=1, config_* unchanged; a following legal packet loads normally.
- Early tlast, count 5, tlast on 3rd data beat -> 3 weightValid pulses, err_code=2, no pkt_done; the next header decodes correctly.
- Missing tlast, count 2, 4 data beats with tlast on the 4th -> 2 pulses, err_code=3, beats 3-4 discarded; back in HDR0 afterwards.
- Reset (reset=0) asserted for one cycle after the 2nd of 4 weights, with LOADER_STATS_EN on -> all valids drop, err=0, pkt_count=0, word_count=0, s_tready=1, FSM in HDR0.
